// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the dual-clock FIFO controllers.
//   - DEFAULT_NUM_ADDRESS : default FIFO depth
//   - addr_width()        : address width for a given depth
//   - bin2gray/gray2bin   : width-agnostic pointer code conversion (up to
//                           CODE_W bits). Zero-extending the input leaves
//                           both codes unchanged in the low bits, so callers
//                           cast to and from their own pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_NUM_ADDRESS = 8;
  localparam int CODE_W              = 32;

  function automatic int addr_width(input int num_address);
    return $clog2(num_address);
  endfunction

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 5'd1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
    logic [CODE_W-1:0] bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_write_controller_if.sv
// -----------------------------------------------------------------------------
// fifo_write_controller_if
// Bundles the producer handshake, the cross-domain pointers and the memory
// write port of the FIFO write-side controller.
//   master : producer / read-domain side (drives push, overflow_clear,
//            rd_ptr_gray; observes everything else)
//   slave  : the write controller itself
// -----------------------------------------------------------------------------
interface fifo_write_controller_if #(
  parameter int ADDR_W = 3
);

  logic              push;
  logic              overflow_clear;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;

  modport master (
    output push, overflow_clear, rd_ptr_gray,
    input  write_enable, write_address, wr_ptr_gray,
    input  full, almost_full, fill_level, overflow
  );

  modport slave (
    input  push, overflow_clear, rd_ptr_gray,
    output write_enable, write_address, wr_ptr_gray,
    output full, almost_full, fill_level, overflow
  );

endinterface

// File: rtl/gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit of the source changes at a time, so each stage can capture
// the bus without a coherency problem.
//   clk, rst : destination clock, asynchronous active-high reset
//   ptr_i    : Gray pointer from the other clock domain
//   ptr_o    : pointer after STAGES flops
// -----------------------------------------------------------------------------
module gray_ptr_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] stage_q [STAGES];

  // Shift the pointer through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= ptr_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign ptr_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_write_controller.sv
// -----------------------------------------------------------------------------
// fifo_write_controller
// Write-side control of a dual-clock FIFO, entirely in the w_clk domain.
//   w_clk, reset : write clock, asynchronous active-high reset
//   bus (slave)  : push / overflow_clear from the producer, rd_ptr_gray from
//                  the read domain; write_enable / write_address to the
//                  memory; wr_ptr_gray to the read domain; full,
//                  almost_full, fill_level and sticky overflow status.
// NUM_ADDRESS must be a power of two >= 2, SYNC_STAGES >= 2 and the
// interface must be built with ADDR_W = $clog2(NUM_ADDRESS).
// -----------------------------------------------------------------------------
module fifo_write_controller
  import fifo_pkg::*;
#(
  parameter int NUM_ADDRESS        = DEFAULT_NUM_ADDRESS,
  parameter int ALMOST_FULL_THRESH = NUM_ADDRESS - 2,
  parameter int SYNC_STAGES        = 2
) (
  input logic                    w_clk,
  input logic                    reset,
  fifo_write_controller_if.slave bus
);

  localparam int ADDR_W = addr_width(NUM_ADDRESS);
  localparam int PTR_W  = ADDR_W + 1;

  // Full means the write pointer is exactly one lap ahead: top two Gray bits
  // inverted, the rest equal. For ADDR_W=1 this inverts both bits.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (ADDR_W - 1);
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(ALMOST_FULL_THRESH);

  logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] rd_sync_s;
  logic [PTR_W-1:0] rd_bin_s;
  logic             write_enable_s;

  gray_ptr_sync #(
    .W      (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (w_clk),
    .rst   (reset),
    .ptr_i (bus.rd_ptr_gray),
    .ptr_o (rd_sync_s)
  );

  // Gate with reset so a push held through reset cannot strobe the memory.
  assign write_enable_s = bus.push & ~full_q & ~reset;

  // Next pointer, flags and fill level, recomputed every cycle so that a
  // moving read pointer updates them even when nothing is pushed.
  always_comb begin
    wr_bin_d  = wr_bin_q + PTR_W'(write_enable_s);
    wr_gray_d = PTR_W'(bin2gray(CODE_W'(wr_bin_d)));
    rd_bin_s  = PTR_W'(gray2bin(CODE_W'(rd_sync_s)));
    full_d    = (wr_gray_d == (rd_sync_s ^ FULL_MASK));
    fill_d    = wr_bin_d - rd_bin_s;
    af_d      = (fill_d >= AF_THRESH);
    ovf_d     = ovf_q;
    // A refused push outranks a simultaneous clear.
    if (bus.push && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.overflow_clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and status registers.
  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  // Memory sees the pre-increment address during the accepting cycle.
  assign bus.write_enable  = write_enable_s;
  assign bus.write_address = wr_bin_q[ADDR_W-1:0];
  assign bus.wr_ptr_gray   = wr_gray_q;
  assign bus.full          = full_q;
  assign bus.almost_full   = af_q;
  assign bus.fill_level    = fill_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_fifo_write_controller.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_controller
// Self-checking bench for fifo_write_controller (NUM_ADDRESS=8, 2 sync
// stages). Expected write addresses go into a scoreboard queue when a push
// is driven and are compared when the DUT raises write_enable; status
// outputs are compared against an occupancy model after every edge.
// -----------------------------------------------------------------------------
module tb_fifo_write_controller;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int PW = 4;

  logic w_clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fifo_write_controller_if #(.ADDR_W(AW)) bus ();

  fifo_write_controller #(
    .NUM_ADDRESS        (N),
    .ALMOST_FULL_THRESH (N - 2),
    .SYNC_STAGES        (2)
  ) dut (
    .w_clk (w_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Reference model state
  logic [PW-1:0] m_bin, m_s0, m_s1, m_fill;
  logic          m_full, m_af, m_ovf;
  int            m_total;
  logic [AW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_reset();
    m_bin = '0; m_s0 = '0; m_s1 = '0; m_fill = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; m_total = 0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check the memory write, advance model, check status.
  task automatic do_cycle(input logic p, input logic clr);
    logic          exp_we;
    logic [PW-1:0] nb, diff, prev_gray;
    bus.push = p;
    bus.overflow_clear = clr;
    #1;
    exp_we = p & ~m_full;
    check_eq("write_enable", bus.write_enable, exp_we);
    if (exp_we) exp_q.push_back(m_bin[AW-1:0]);
    if (bus.write_enable) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check_eq("write_address", bus.write_address, exp_q.pop_front());
    end
    exp_q.delete();
    nb   = m_bin + {3'b000, exp_we};
    diff = nb - g2b(m_s1);
    if (p && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_s1 = m_s0;
    m_s0 = bus.rd_ptr_gray;
    m_bin = nb;
    m_full = (diff == 4'd8);
    m_fill = diff;
    m_af = (diff >= 4'd6);
    if (exp_we) m_total++;
    prev_gray = bus.wr_ptr_gray;
    @(posedge w_clk);
    #1;
    check_eq("full", bus.full, m_full);
    check_eq("almost_full", bus.almost_full, m_af);
    check_eq("fill_level", bus.fill_level, m_fill);
    check_eq("overflow", bus.overflow, m_ovf);
    check_eq("wr_ptr_gray", bus.wr_ptr_gray, b2g(m_bin));
    check_eq("addr_after", bus.write_address, m_bin[AW-1:0]);
    check_eq("gray_one_bit", $countones(prev_gray ^ bus.wr_ptr_gray) <= 1, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, bus.write_enable, 1'b0);
    check_eq({tag, "_addr"}, bus.write_address, 3'd0);
    check_eq({tag, "_gray"}, bus.wr_ptr_gray, 4'd0);
    check_eq({tag, "_full"}, bus.full, 1'b0);
    check_eq({tag, "_af"}, bus.almost_full, 1'b0);
    check_eq({tag, "_fill"}, bus.fill_level, 4'd0);
    check_eq({tag, "_ovf"}, bus.overflow, 1'b0);
  endtask

  task automatic apply_reset();
    bus.rd_ptr_gray = 4'd0;
    bus.overflow_clear = 1'b0;
    bus.push = 1'b1;
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge w_clk);
    #1;
    check_all_zero("rst_hold");
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] rd_bin;
    n_checks = 0;
    n_errors = 0;
    model_reset();

    // Reset with push held high
    apply_reset();
    #1;
    check_eq("we_after_release", bus.write_enable, 1'b1);

    // Fill to full with the reader idle
    for (int i = 1; i <= N; i++) begin
      do_cycle(1'b1, 1'b0);
      if (i == 5) check_eq("af_at5", bus.almost_full, 1'b0);
      if (i == 6) check_eq("af_at6", bus.almost_full, 1'b1);
      if (i == 7) check_eq("full_at7", bus.full, 1'b0);
    end
    check_eq("full_at8", bus.full, 1'b1);
    check_eq("fill_at8", bus.fill_level, 4'd8);
    check_eq("gray_at8", bus.wr_ptr_gray, 4'b1100);
    do_cycle(1'b1, 1'b0);
    check_eq("ovf_set", bus.overflow, 1'b1);
    check_eq("gray_held", bus.wr_ptr_gray, 4'b1100);

    // Clear collides with a refused push, then clear alone
    do_cycle(1'b1, 1'b1);
    check_eq("ovf_set_wins", bus.overflow, 1'b1);
    do_cycle(1'b0, 1'b1);
    check_eq("ovf_cleared", bus.overflow, 1'b0);

    // Reader frees one slot; observe the sync latency
    bus.rd_ptr_gray = 4'b0001;
    do_cycle(1'b0, 1'b0);
    check_eq("full_lat1", bus.full, 1'b1);
    do_cycle(1'b0, 1'b0);
    check_eq("full_lat2", bus.full, 1'b1);
    do_cycle(1'b0, 1'b0);
    check_eq("full_released", bus.full, 1'b0);
    check_eq("fill_7", bus.fill_level, 4'd7);
    bus.push = 1'b1;
    #1;
    check_eq("next_addr0", bus.write_address, 3'd0);
    do_cycle(1'b1, 1'b0);
    check_eq("refull", bus.full, 1'b1);

    // Streaming with the reader three writes behind
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      rd_bin = (m_total >= 3) ? 4'(m_total - 3) : 4'd0;
      bus.rd_ptr_gray = b2g(rd_bin);
      do_cycle(1'b1, 1'b0);
      check_eq("stream_not_full", bus.full, 1'b0);
      if (i == 7) check_eq("msb_before8", bus.wr_ptr_gray[3], 1'b0);
      if (i == 8) check_eq("msb_at8", bus.wr_ptr_gray[3], 1'b1);
      if (i == 16) check_eq("msb_at16", bus.wr_ptr_gray[3], 1'b0);
    end
    check_eq("stream_addr_end", bus.write_address, 3'd4);

    // Reset mid-cycle after five pushes
    apply_reset();
    bus.rd_ptr_gray = 4'd0;
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0);
    check_eq("pre_rst_addr", bus.write_address, 3'd5);
    check_eq("pre_rst_fill", bus.fill_level, 4'd5);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_addr", bus.write_address, 3'd0);
    check_eq("midrst_fill", bus.fill_level, 4'd0);
    check_eq("midrst_gray", bus.wr_ptr_gray, 4'd0);
    check_eq("midrst_we", bus.write_enable, 1'b0);
    @(posedge w_clk);
    #1;
    reset = 1'b0;
    model_reset();
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
